// File: rtl/mat4_add.sv
// mat4_add: sequential element-wise adder for two 4 x 64-bit vectors.
// One shared 64-bit adder processes one element per cycle. The result
// register c and the done pulse are loaded together on the final add cycle.
module mat4_add (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] c,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [1:0]  idx_reg;
  logic [63:0] a_q_reg   [0:3];
  logic [63:0] b_q_reg   [0:3];
  logic [63:0] acc_reg   [0:3];
  logic [255:0] c_reg;
  logic        done_reg;

  // Unpacked views of the input buses, one 64-bit element per entry.
  logic [63:0] a_elem [0:3];
  logic [63:0] b_elem [0:3];

  // The single shared adder; the carry-out is dropped so each element
  // wraps modulo 2^64 on its own.
  logic [63:0] sum_next;
  assign sum_next = a_q_reg[idx_reg] + b_q_reg[idx_reg];

  // Result image loaded into c on the last add cycle: elements 0..2 come
  // from the accumulation registers, element 3 straight from the adder.
  logic [255:0] c_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign a_elem[gi] = a[64*gi +: 64];
      assign b_elem[gi] = b[64*gi +: 64];
    end
    for (gi = 0; gi < 3; gi++) begin : g_pack
      assign c_next[64*gi +: 64] = acc_reg[gi];
    end
  endgenerate
  assign c_next[255:192] = sum_next;

  // Control FSM with registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      c_reg     <= '0;
      done_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_q_reg[i] <= '0;
        b_q_reg[i] <= '0;
        acc_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            for (int i = 0; i < 4; i++) begin
              a_q_reg[i] <= a_elem[i];
              b_q_reg[i] <= b_elem[i];
            end
            idx_reg   <= 2'd0;
            state_reg <= ADD;
          end
        end
        ADD: begin
          acc_reg[idx_reg] <= sum_next;
          idx_reg          <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            c_reg     <= c_next;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign c    = c_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_mat4_add.sv
// Self-checking bench for mat4_add: directed scenarios plus randomized
// operations compared against an element-wise reference sum.
module tb_mat4_add;

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] c;
  logic         done;

  int checks   = 0;
  int failures = 0;

  mat4_add dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element-wise sum, each lane truncated to 64 bits.
  function automatic logic [255:0] ref_add(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    logic [63:0]  xe, ye;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      xe = x[64*i +: 64];
      ye = y[64*i +: 64];
      r[64*i +: 64] = xe + ye;
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation with a single start pulse; a/b are scrambled right after
  // the capture edge. Checks done timing and c before, at and after done.
  task automatic run_op(input string tag, input logic [255:0] xa, input logic [255:0] xb,
                        input logic [255:0] exp, input logic [255:0] prev_c);
    a = xa; b = xb; start = 1'b1;
    tick();                       // capture edge N
    start = 1'b0;
    a = rand256(); b = rand256();
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk({tag, "_busy_done"}, {255'd0, done}, 256'd0);
      chk({tag, "_busy_c"}, c, prev_c);
    end
    tick();                       // N+4
    chk({tag, "_done_hi"}, {255'd0, done}, 256'd1);
    chk({tag, "_c"}, c, exp);
    tick();                       // N+5
    chk({tag, "_done_lo"}, {255'd0, done}, 256'd0);
    chk({tag, "_c_hold"}, c, exp);
    $display("op %s a=%h b=%h c=%h", tag, xa, xb, c);
  endtask

  logic [255:0] last_c;
  logic [255:0] ta, tb_, ta2, tb2, exp1, exp2;
  int           first_done, second_done, cyc;

  initial begin
    rst = 1'b0; start = 1'b1; a = rand256(); b = rand256();
    last_c = '0;

    // Reset held with start high: nothing begins.
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_c", c, 256'd0);
      chk("rst_done", {255'd0, done}, 256'd0);
    end
    start = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_done", {255'd0, done}, 256'd0);
      chk("post_rst_c", c, 256'd0);
    end

    // Basic add against a fixed expected constant.
    ta = {64'd4, 64'd3, 64'd2, 64'd1};
    exp1 = 256'h0000000000000008_0000000000000006_0000000000000004_0000000000000002;
    run_op("basic", ta, ta, exp1, last_c);
    last_c = exp1;

    // Per-element wrap with no carry into the next lane.
    ta  = {64'd5, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF};
    tb_ = {64'd5, 64'd5, 64'd0, 64'd1};
    exp1 = {64'd10, 64'd10, 64'd0, 64'd0};
    run_op("wrap", ta, tb_, exp1, last_c);
    last_c = exp1;

    // Start held high throughout; operands changed after capture.
    ta = rand256(); tb_ = rand256();
    ta2 = rand256(); tb2 = rand256();
    exp1 = ref_add(ta, tb_);
    exp2 = ref_add(ta2, tb2);
    a = ta; b = tb_; start = 1'b1;
    first_done = -1; second_done = -1;
    cyc = 0;
    tick();                       // capture edge N
    for (cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == 1) begin a = ta2; b = tb2; end
      tick();
      if (cyc == 6) start = 1'b0; // second capture happened at N+6
      if (done === 1'b1) begin
        if (first_done < 0) begin
          first_done = cyc;
          chk("busy_c1", c, exp1);
        end else if (second_done < 0) begin
          second_done = cyc;
          chk("busy_c2", c, exp2);
        end
      end
    end
    chk("busy_first_lat", 256'(first_done), 256'd4);
    chk("busy_period", 256'(second_done - first_done), 256'd6);
    $display("op busy first_done=%0d second_done=%0d c=%h", first_done, second_done, c);
    last_c = exp2;
    tick();

    // Reset two cycles after start aborts the operation.
    a = rand256(); b = rand256(); start = 1'b1;
    tick();                       // N
    start = 1'b0;
    tick();                       // N+1
    tick();                       // N+2
    rst = 1'b0;
    tick();                       // N+3: reset applied
    chk("abort_c", c, 256'd0);
    chk("abort_done", {255'd0, done}, 256'd0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", {255'd0, done}, 256'd0);
      chk("abort_c_zero", c, 256'd0);
    end
    $display("op abort c=%h done=%b", c, done);
    last_c = '0;
    ta = rand256(); tb_ = rand256();
    exp1 = ref_add(ta, tb_);
    run_op("after_abort", ta, tb_, exp1, last_c);
    last_c = exp1;

    // Idle hold: no start for 20 cycles.
    a = rand256(); b = rand256();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_done", {255'd0, done}, 256'd0);
      chk("idle_c", c, last_c);
    end
    $display("op idle_hold c=%h", c);

    // Randomized operations, some with lanes forced to the wrap boundary.
    for (int n = 0; n < 8; n++) begin
      ta = rand256(); tb_ = rand256();
      if (n % 2 == 1) begin
        ta[64*(n%4) +: 64] = 64'hFFFFFFFFFFFFFFFF;
        tb_[64*(n%4) +: 64] = 64'd1 + 64'($urandom_range(0, 3));
      end
      exp1 = ref_add(ta, tb_);
      run_op($sformatf("rand%0d", n), ta, tb_, exp1, last_c);
      last_c = exp1;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
